// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, state enum and ROM address helper for the sprite blitter
package sprite_pkg;

    localparam int         SCREEN_W    = 640;
    localparam int         SCREEN_H    = 480;
    localparam logic [7:0] TRANSPARENT = 8'h00;
    localparam int         ROM_AW      = 21;
    localparam int         FB_AW       = 19;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Sprite ROM addressing shared with the animation blocks: base + row*width + col.
    // row*width+col always fits 20 bits; the final add wraps modulo 2^21.
    function automatic logic [ROM_AW-1:0] sprite_rom_addr(
        input logic [ROM_AW-1:0] base,
        input logic [9:0]        width,
        input logic [9:0]        row,
        input logic [9:0]        col
    );
        logic [19:0] offs;
        offs = ({10'b0, row} * {10'b0, width}) + {10'b0, col};
        return base + {1'b0, offs};
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// rtl/fb_addr_calc.sv - screen position, on-screen test and frame buffer address for one sprite pixel
//
// Ports:
//   dest_x_i, dest_y_i : sprite top-left screen position
//   col_i, row_i       : pixel position inside the sprite
//   on_screen_o        : pixel lands inside SCREEN_W x SCREEN_H
//   fb_addr_o          : py*SCREEN_W + px (meaningful only when on_screen_o)
module fb_addr_calc
    import sprite_pkg::*;
#(
    parameter int SCREEN_W = sprite_pkg::SCREEN_W,
    parameter int SCREEN_H = sprite_pkg::SCREEN_H
) (
    input  logic [9:0]       dest_x_i,
    input  logic [9:0]       dest_y_i,
    input  logic [9:0]       col_i,
    input  logic [9:0]       row_i,
    output logic             on_screen_o,
    output logic [FB_AW-1:0] fb_addr_o
);

    localparam logic [10:0]      SW11  = 11'(SCREEN_W);
    localparam logic [10:0]      SH11  = 11'(SCREEN_H);
    localparam logic [FB_AW-1:0] SW_FB = FB_AW'(SCREEN_W);

    // 11 bits so that dest + offset never wraps back onto the screen.
    logic [10:0]      px;
    logic [10:0]      py;
    logic [FB_AW-1:0] px_w;
    logic [FB_AW-1:0] py_w;

    assign px   = {1'b0, dest_x_i} + {1'b0, col_i};
    assign py   = {1'b0, dest_y_i} + {1'b0, row_i};
    assign px_w = {{(FB_AW-11){1'b0}}, px};
    assign py_w = {{(FB_AW-11){1'b0}}, py};

    assign on_screen_o = (px < SW11) && (py < SH11);

    generate
        if (SCREEN_W == 640) begin : g_shift
            // 640 = 512 + 128, so the row product is two shifts and an add.
            assign fb_addr_o = (py_w << 9) + (py_w << 7) + px_w;
        end else begin : g_mul
            assign fb_addr_o = (py_w * SW_FB) + px_w;
        end
    endgenerate

endmodule

// File: rtl/sprite_frame_writer.sv
// rtl/sprite_frame_writer.sv - copies one sprite frame from ROM into the frame buffer with clipping
//
// Ports:
//   Clk, Reset                 : clock, synchronous active-high reset
//   start                      : request, sampled only when idle
//   spriteBase                 : ROM address of pixel (0,0)
//   destX, destY               : screen position of the top-left pixel
//   spriteWidth, spriteHeight  : frame size in pixels
//   romAddr / romData          : sprite ROM, data valid one cycle after address
//   fbAddr, fbData, fbWe       : frame buffer write request, held until fbReady
//   fbReady                    : arbiter grant
//   busy, done                 : status; done pulses once at the end of a frame
module sprite_frame_writer
    import sprite_pkg::*;
#(
    parameter int         SCREEN_W    = sprite_pkg::SCREEN_W,
    parameter int         SCREEN_H    = sprite_pkg::SCREEN_H,
    parameter logic [7:0] TRANSPARENT = sprite_pkg::TRANSPARENT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [20:0] spriteBase,
    input  logic [9:0]  destX,
    input  logic [9:0]  destY,
    input  logic [9:0]  spriteWidth,
    input  logic [9:0]  spriteHeight,
    output logic [20:0] romAddr,
    input  logic [7:0]  romData,
    output logic [18:0] fbAddr,
    output logic [7:0]  fbData,
    output logic        fbWe,
    input  logic        fbReady,
    output logic        busy,
    output logic        done
);

    state_e state_q, state_d;

    // Request parameters frozen at start.
    logic [ROM_AW-1:0] base_q, base_d;
    logic [9:0]        dx_q, dx_d;
    logic [9:0]        dy_q, dy_d;
    logic [9:0]        w_q, w_d;
    logic [9:0]        h_q, h_d;

    logic [9:0]        col_q, col_d;
    logic [9:0]        row_q, row_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
    logic [7:0]        fb_data_q, fb_data_d;

    logic             on_screen;
    logic [FB_AW-1:0] pix_fb_addr;

    fb_addr_calc #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_fb_addr_calc (
        .dest_x_i    (dx_q),
        .dest_y_i    (dy_q),
        .col_i       (col_q),
        .row_i       (row_q),
        .on_screen_o (on_screen),
        .fb_addr_o   (pix_fb_addr)
    );

    // Row-major walk: the next pixel position and whether the current one ends the frame.
    logic       col_last;
    logic       pix_last;
    logic [9:0] col_adv;
    logic [9:0] row_adv;

    assign col_last = (col_q == (w_q - 10'd1));
    assign pix_last = col_last && (row_q == (h_q - 10'd1));
    assign col_adv  = col_last ? 10'd0 : (col_q + 10'd1);
    assign row_adv  = col_last ? (row_q + 10'd1) : row_q;

    always_comb begin
        logic advance;
        advance    = 1'b0;
        state_d    = state_q;
        base_d     = base_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        rom_addr_d = rom_addr_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = spriteBase;
                    dx_d   = destX;
                    dy_d   = destY;
                    w_d    = spriteWidth;
                    h_d    = spriteHeight;
                    col_d  = 10'd0;
                    row_d  = 10'd0;
                    if ((spriteWidth == 10'd0) || (spriteHeight == 10'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_FETCH;
                        rom_addr_d = spriteBase;
                    end
                end
            end
            // romAddr was loaded on entry to FETCH, so the ROM answers during WAIT.
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if ((romData != TRANSPARENT) && on_screen) begin
                    fb_addr_d = pix_fb_addr;
                    fb_data_d = romData;
                    state_d   = S_WRITE;
                end else begin
                    advance = 1'b1;
                end
            end
            S_WRITE: begin
                if (fbReady) begin
                    advance = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            col_d = col_adv;
            row_d = row_adv;
            if (pix_last) begin
                state_d = S_DONE;
            end else begin
                state_d    = S_FETCH;
                rom_addr_d = sprite_rom_addr(base_q, w_q, row_adv, col_adv);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            rom_addr_q <= '0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            rom_addr_q <= rom_addr_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    // State-decoded strobes fall in the same cycle the state leaves, so reset drops fbWe at once.
    assign romAddr = rom_addr_q;
    assign fbAddr  = fb_addr_q;
    assign fbData  = fb_data_q;
    assign fbWe    = (state_q == S_WRITE);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

endmodule
